// File: rtl/k2red_stream.sv
// k2red_stream: pipelined K^2-RED reducer, T = (k^2*C) mod q for q = k*2^W+1, chosen per transaction from an NQ-entry table
// Ports: clk/rst_n; in_valid/in_ready/in_c/in_qsel/in_tag accept side; out_valid/out_ready/out_t/out_tag result side;
// cfg_we/cfg_addr/cfg_qh/cfg_l1/cfg_l2/cfg_l3/cfg_l3en table write; busy when any stage holds a transaction.
module k2red_stream #(
  parameter int LOGQ = 32,
  parameter int LOGQH = LOGQ - 17,
  parameter int LOGL = 4,
  parameter int NQ = 4,
  parameter int TAGW = 8,
  parameter int FF_SHF = 1,
  localparam int LOGNQ = NQ > 1 ? $clog2(NQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*LOGQ-1:0] in_c,
  input  logic [LOGNQ-1:0]  in_qsel,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   out_t,
  output logic [TAGW-1:0]   out_tag,
  input  logic              cfg_we,
  input  logic [LOGNQ-1:0]  cfg_addr,
  input  logic [LOGQH-1:0]  cfg_qh,
  input  logic [LOGL-1:0]   cfg_l1,
  input  logic [LOGL-1:0]   cfg_l2,
  input  logic [LOGL-1:0]   cfg_l3,
  input  logic              cfg_l3en,
  output logic              busy
);
  localparam int W = LOGQ - LOGQH;
  localparam int HW = 2*LOGQ - W;
  localparam int C1W = HW + 1;
  localparam int TW = LOGQ + 3;
  localparam int KB = LOGQ - 1 - W;
  typedef struct packed {
    logic [LOGQH-1:0] qh;
    logic [LOGL-1:0]  l1;
    logic [LOGL-1:0]  l2;
    logic [LOGL-1:0]  l3;
    logic             l3en;
  } ent_t;
  localparam int EW = $bits(ent_t);
  localparam int P2W = 1 + TAGW + EW + HW + 4*C1W;
  localparam int P3W = 1 + TAGW + LOGQH + 5*TW;

  ent_t tbl [NQ];
  ent_t sel_ent, a_ent, b_ent, p2_ent, c_ent;
  logic adv, a_v, b_v, p2_v, c_v, p3_v, d_v;
  logic [2*LOGQ-1:0] a_c;
  logic [TAGW-1:0] a_tag, b_tag, p2_tag, c_tag, p3_tag, d_tag;
  logic [HW-1:0] b_ch, p2_ch;
  logic [W:0] b_cl;
  logic [C1W-1:0] bx, p2_t0, p2_t1, p2_t2, p2_t3, c_c1;
  logic [TW-1:0] cx, hx, p3_h, p3_t0, p3_t1, p3_t2, p3_t3, d_t, qx, tm;
  logic [LOGQH-1:0] p3_qh, d_qh;
  logic [P2W-1:0] p2_d, p2_q;
  logic [P3W-1:0] p3_d, p3_q;

  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign busy = a_v | b_v | p2_v | c_v | p3_v | d_v | out_valid;
  assign sel_ent = int'(in_qsel) < NQ ? tbl[in_qsel] : '0;

  // Writes land at the edge, so a same-cycle accept still captures the old entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) tbl[i] <= '0;
    end else if (cfg_we && int'(cfg_addr) < NQ) begin
      tbl[cfg_addr] <= {cfg_qh, cfg_l1, cfg_l2, cfg_l3, cfg_l3en};
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_v <= '0; a_c <= '0; a_tag <= '0; a_ent <= '0;
      b_v <= '0; b_ch <= '0; b_cl <= '0; b_tag <= '0; b_ent <= '0;
    end else if (adv) begin
      a_v <= in_valid; a_c <= in_c; a_tag <= in_tag; a_ent <= sel_ent;
      b_v <= a_v; b_ch <= a_c[2*LOGQ-1:W]; b_cl <= {1'b0, a_c[W-1:0]}; b_tag <= a_tag; b_ent <= a_ent;
    end

  // k*x = x<<(LOGQ-1-W) + x<<L1 - x<<L2 + l3en*(x<<L3)
  assign bx = C1W'(b_cl);
  assign p2_d = {b_v, b_tag, b_ent, b_ch, bx << KB, bx << b_ent.l1, bx << b_ent.l2,
                 b_ent.l3en ? bx << b_ent.l3 : {C1W{1'b0}}};
  assign {p2_v, p2_tag, p2_ent, p2_ch, p2_t0, p2_t1, p2_t2, p2_t3} = p2_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_v <= '0; c_c1 <= '0; c_tag <= '0; c_ent <= '0;
    end else if (adv) begin
      c_v <= p2_v; c_c1 <= p2_t0 + p2_t1 - p2_t2 + p2_t3 - C1W'(p2_ch); c_tag <= p2_tag; c_ent <= p2_ent;
    end

  assign cx = TW'({1'b0, c_c1[W-1:0]});
  assign hx = {{(TW-C1W+W){c_c1[C1W-1]}}, c_c1[C1W-1:W]};
  assign p3_d = {c_v, c_tag, c_ent.qh, hx, cx << KB, cx << c_ent.l1, cx << c_ent.l2,
                 c_ent.l3en ? cx << c_ent.l3 : {TW{1'b0}}};
  assign {p3_v, p3_tag, p3_qh, p3_h, p3_t0, p3_t1, p3_t2, p3_t3} = p3_q;

  // Optional register between each barrel-shift and its adder.
  if (FF_SHF != 0) begin : g_shf
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        p2_q <= '0; p3_q <= '0;
      end else if (adv) begin
        p2_q <= p2_d; p3_q <= p3_d;
      end
  end else begin : g_comb
    assign p2_q = p2_d;
    assign p3_q = p3_d;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_v <= '0; d_t <= '0; d_qh <= '0; d_tag <= '0;
    end else if (adv) begin
      d_v <= p3_v; d_t <= p3_t0 + p3_t1 - p3_t2 + p3_t3 - p3_h; d_qh <= p3_qh; d_tag <= p3_tag;
    end

  // Tint lies in (-q, 2q) for legal inputs, so one signed correction fully reduces it.
  assign qx = TW'({d_qh, {(W-1){1'b0}}, 1'b1});
  assign tm = d_t - qx;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= '0; out_t <= '0; out_tag <= '0;
    end else if (adv) begin
      out_valid <= d_v;
      out_t <= LOGQ'(!tm[TW-1] ? tm : d_t[TW-1] ? d_t + qx : d_t);
      out_tag <= d_tag;
    end
endmodule
